// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM constants for the arbiter slice: bus widths, command codes,
// refresh timing defaults and the arbiter state encoding.
package sdram_arbiter_pkg;

   localparam int ASIZE = 12;
   localparam int BSIZE = 2;

   // {Cs_n, Ras_n, Cas_n, We_n}
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_AREF  = 4'b0001;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_LMR   = 4'b0000;

   localparam int REF_PERIOD_DEF = 780;
   localparam int TRP_DEF        = 2;
   localparam int TRFC_DEF       = 7;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_AREF
   } arb_state_e;

   function automatic int aref_len(input int trp, input int trfc);
      return 3 + trp + 2 * trfc;
   endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Arbiter-facing bundle: init/write/read engine inputs and the shared SDRAM
// command bus. The arbiter takes the master view, the surroundings the slave view.
interface sdram_arbiter_if;
   import sdram_arbiter_pkg::*;

   logic             Init_done;
   logic [3:0]       Init_cmd;
   logic [ASIZE-1:0] Init_addr;
   logic             Wr_req;
   logic [3:0]       Wr_cmd;
   logic [ASIZE-1:0] Wr_addr;
   logic [BSIZE-1:0] Wr_ba;
   logic             Wr_done;
   logic             Rd_req;
   logic [3:0]       Rd_cmd;
   logic [ASIZE-1:0] Rd_addr;
   logic [BSIZE-1:0] Rd_ba;
   logic             Rd_done;
   logic             Wr_en;
   logic             Rd_en;
   logic             Aref_pend;
   logic             Aref_busy;
   logic [3:0]       Command;
   logic [ASIZE-1:0] Saddr;
   logic [BSIZE-1:0] Ba;

   modport master (
      input  Init_done, Init_cmd, Init_addr,
      input  Wr_req, Wr_cmd, Wr_addr, Wr_ba, Wr_done,
      input  Rd_req, Rd_cmd, Rd_addr, Rd_ba, Rd_done,
      output Wr_en, Rd_en, Aref_pend, Aref_busy, Command, Saddr, Ba
   );

   modport slave (
      output Init_done, Init_cmd, Init_addr,
      output Wr_req, Wr_cmd, Wr_addr, Wr_ba, Wr_done,
      output Rd_req, Rd_cmd, Rd_addr, Rd_ba, Rd_done,
      input  Wr_en, Rd_en, Aref_pend, Aref_busy, Command, Saddr, Ba
   );

endinterface

// File: rtl/sdram_arbiter_aref.sv
// PRECHARGE-all / double AUTO REFRESH sequencer. A start pulse loads the
// PRECHARGE; outputs are registered and done marks the last cycle of the run.
module sdram_arbiter_aref
   import sdram_arbiter_pkg::*;
#(
   parameter int TRP  = TRP_DEF,
   parameter int TRFC = TRFC_DEF
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             start,
   output logic [3:0]       cmd,
   output logic [ASIZE-1:0] saddr,
   output logic             busy,
   output logic             done
);

   localparam int LAST    = aref_len(TRP, TRFC) - 1;
   localparam int KW      = $clog2(LAST + 1);
   localparam int K_AREF1 = 1 + TRP;
   localparam int K_AREF2 = 2 + TRP + TRFC;

   typedef logic [KW-1:0] k_t;

   k_t               k_q, k_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [ASIZE-1:0] addr_q, addr_d;
   logic             busy_q, busy_d;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         k_q    <= '0;
         cmd_q  <= CMD_NOP;
         addr_q <= '0;
         busy_q <= 1'b0;
      end else begin
         k_q    <= k_d;
         cmd_q  <= cmd_d;
         addr_q <= addr_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      k_d    = k_q;
      cmd_d  = CMD_NOP;
      addr_d = '0;
      busy_d = busy_q;
      done   = busy_q && (k_q == k_t'(LAST));
      if (start) begin
         k_d        = '0;
         busy_d     = 1'b1;
         cmd_d      = CMD_PRE;
         addr_d[10] = 1'b1;   // A10 high: precharge all banks
      end else if (busy_q) begin
         if (done) begin
            k_d    = '0;
            busy_d = 1'b0;
         end else begin
            k_d = k_q + k_t'(1);
            if (k_d == k_t'(K_AREF1) || k_d == k_t'(K_AREF2)) cmd_d = CMD_AREF;
         end
      end
   end

   assign cmd   = cmd_q;
   assign saddr = addr_q;
   assign busy  = busy_q;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: fixed priority refresh > write > read once init is done,
// with its own refresh interval timer and refresh command sequencer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | init block owns the bus, pass-through of Init_cmd/Init_addr
// ST_IDLE  | bus parked on NOP, picks next owner by priority
// ST_WRITE | write engine granted until Wr_done
// ST_READ  | read engine granted until Rd_done
// ST_AREF  | refresh sequencer drives PRECHARGE + 2x AUTO REFRESH
module sdram_arbiter
   import sdram_arbiter_pkg::*;
#(
   parameter int REF_PERIOD = REF_PERIOD_DEF,
   parameter int TRP        = TRP_DEF,
   parameter int TRFC       = TRFC_DEF
) (
   input  logic            Clk,
   input  logic            Rst_n,
   sdram_arbiter_if.master bus
);

   localparam int TW = $clog2(REF_PERIOD);
   typedef logic [TW-1:0] tmr_t;
   localparam tmr_t TMR_TOP = tmr_t'(REF_PERIOD - 1);

   arb_state_e       state_q, state_d;
   tmr_t             tmr_q, tmr_d;
   logic             pend_q, pend_d;
   logic             tmr_tc;
   logic             aref_start;
   logic             aref_done;
   logic             aref_busy;
   logic [3:0]       aref_cmd;
   logic [ASIZE-1:0] aref_addr;

   sdram_arbiter_aref #(.TRP(TRP), .TRFC(TRFC)) u_aref (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .start (aref_start),
      .cmd   (aref_cmd),
      .saddr (aref_addr),
      .busy  (aref_busy),
      .done  (aref_done)
   );

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= ST_INIT;
         tmr_q   <= TMR_TOP;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         pend_q  <= pend_d;
      end
   end

   // Down-counter: TMR_TOP is interval count 0, zero is the terminal count.
   always_comb begin
      tmr_tc = (state_q != ST_INIT) && (tmr_q == '0);
      tmr_d  = tmr_q;
      if (state_q != ST_INIT) tmr_d = tmr_tc ? TMR_TOP : tmr_q - tmr_t'(1);
      pend_d = pend_q | tmr_tc;
      if (aref_start) pend_d = 1'b0;
   end

   assign bus.Aref_pend = pend_q | tmr_tc;

   always_comb begin
      state_d    = state_q;
      aref_start = 1'b0;
      case (state_q)
         ST_INIT:  if (bus.Init_done) state_d = ST_IDLE;
         ST_IDLE: begin
            if (bus.Aref_pend) begin
               state_d    = ST_AREF;
               aref_start = 1'b1;
            end else if (bus.Wr_req) begin
               state_d = ST_WRITE;
            end else if (bus.Rd_req) begin
               state_d = ST_READ;
            end
         end
         ST_WRITE: if (bus.Wr_done) state_d = ST_IDLE;
         ST_READ:  if (bus.Rd_done) state_d = ST_IDLE;
         ST_AREF:  if (aref_done)   state_d = ST_IDLE;
         default:  state_d = ST_INIT;
      endcase
   end

   always_comb begin
      bus.Wr_en     = (state_q == ST_WRITE);
      bus.Rd_en     = (state_q == ST_READ);
      bus.Aref_busy = aref_busy;
      bus.Command   = CMD_NOP;
      bus.Saddr     = '0;
      bus.Ba        = '0;
      case (state_q)
         ST_INIT: begin
            bus.Command = bus.Init_cmd;
            bus.Saddr   = bus.Init_addr;
         end
         ST_WRITE: begin
            bus.Command = bus.Wr_cmd;
            bus.Saddr   = bus.Wr_addr;
            bus.Ba      = bus.Wr_ba;
         end
         ST_READ: begin
            bus.Command = bus.Rd_cmd;
            bus.Saddr   = bus.Rd_addr;
            bus.Ba      = bus.Rd_ba;
         end
         ST_AREF: begin
            bus.Command = aref_cmd;
            bus.Saddr   = aref_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init pass-through, refresh timing and
// sequence, write/read priority, refresh during a burst, reset mid-refresh.
module tb_sdram_arbiter;
   import sdram_arbiter_pkg::*;

   localparam int RP = 780;
   // {Wr_en, Rd_en, Aref_pend, Aref_busy, Command, Saddr, Ba}
   localparam logic [21:0] V_IDLE = {4'b0000, 4'b0111, 12'h000, 2'b00};
   localparam logic [21:0] V_PEND = {4'b0010, 4'b0111, 12'h000, 2'b00};
   localparam logic [21:0] V_PRE  = {4'b0001, 4'b0010, 12'h400, 2'b00};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_arbiter_if bus ();

   sdram_arbiter dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int tcount   = 0;
   bit running  = 1'b0;

   function automatic logic [21:0] obs();
      return {bus.Wr_en, bus.Rd_en, bus.Aref_pend, bus.Aref_busy,
              bus.Command, bus.Saddr, bus.Ba};
   endfunction

   task automatic step();
      @(negedge clk);
      if (running) tcount = (tcount == RP - 1) ? 0 : tcount + 1;
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 2 * RP && tcount != target; i++) step();
   endtask

   task automatic test_reset();
      logic [21:0] exp;
      bus.Init_done = 1'b0; bus.Init_cmd = 4'b0000; bus.Init_addr = 12'h123;
      bus.Wr_req = 1'b0; bus.Wr_cmd = 4'b0111; bus.Wr_addr = '0; bus.Wr_ba = '0; bus.Wr_done = 1'b0;
      bus.Rd_req = 1'b0; bus.Rd_cmd = 4'b0111; bus.Rd_addr = '0; bus.Rd_ba = '0; bus.Rd_done = 1'b0;
      rst_n = 1'b0;
      repeat (200) step();
      n_checks++;
      if (obs() !== {4'b0000, 4'b0000, 12'h123, 2'b00}) begin
         n_fail++; $display("FAIL reset_state: got %h expected %h", obs(), {4'b0000, 4'b0000, 12'h123, 2'b00});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.Init_cmd  = 4'(i + 3);
         bus.Init_addr = 12'(i * 37 + 5);
         #1;
         exp = {4'b0000, 4'(i + 3), 12'(i * 37 + 5), 2'b00};
         n_checks++;
         if (obs() !== exp) begin
            n_fail++; $display("FAIL init_pass_%0d: got %h expected %h", i, obs(), exp);
         end
         step();
      end
      bus.Init_cmd = 4'b0010; bus.Init_addr = 12'h400; bus.Init_done = 1'b1;
      step();
      running = 1'b1; tcount = 0;
      bus.Init_done = 1'b0; bus.Init_cmd = 4'b0000;
      #1;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fail++; $display("FAIL idle_after_init: got %h expected %h", obs(), V_IDLE);
      end
      step();
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fail++; $display("FAIL init_done_ignored: got %h expected %h", obs(), V_IDLE);
      end
   endtask

   task automatic test_refresh();
      logic [21:0] exp;
      run_to(RP - 2);
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fail++; $display("FAIL pend_before_tc: got %h expected %h", obs(), V_IDLE);
      end
      step();
      n_checks++;
      if (obs() !== V_PEND) begin
         n_fail++; $display("FAIL pend_at_tc: got %h expected %h", obs(), V_PEND);
      end
      step();
      n_checks++;
      if (obs() !== V_PRE) begin
         n_fail++; $display("FAIL aref_k0: got %h expected %h", obs(), V_PRE);
      end
      for (int k = 1; k <= 18; k++) begin
         step();
         exp = {4'b0001, (k == 3 || k == 11) ? 4'b0001 : 4'b0111, 12'h000, 2'b00};
         n_checks++;
         if (obs() !== exp) begin
            n_fail++; $display("FAIL aref_k%0d: got %h expected %h", k, obs(), exp);
         end
      end
      step();
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fail++; $display("FAIL aref_exit: got %h expected %h", obs(), V_IDLE);
      end
   endtask

   task automatic test_priority();
      bus.Wr_req = 1'b1; bus.Wr_cmd = 4'b0100; bus.Wr_addr = 12'hABC; bus.Wr_ba = 2'd2;
      bus.Rd_req = 1'b1; bus.Rd_cmd = 4'b0101; bus.Rd_addr = 12'h155; bus.Rd_ba = 2'd1;
      step();
      n_checks++;
      if (obs() !== {4'b1000, 4'b0100, 12'hABC, 2'd2}) begin
         n_fail++; $display("FAIL write_wins: got %h expected %h", obs(), {4'b1000, 4'b0100, 12'hABC, 2'd2});
      end
      bus.Wr_addr = 12'h0F0; bus.Rd_done = 1'b1;
      #1;
      n_checks++;
      if (obs() !== {4'b1000, 4'b0100, 12'h0F0, 2'd2}) begin
         n_fail++; $display("FAIL write_addr_follow: got %h expected %h", obs(), {4'b1000, 4'b0100, 12'h0F0, 2'd2});
      end
      step();
      bus.Rd_done = 1'b0;
      n_checks++;
      if (obs() !== {4'b1000, 4'b0100, 12'h0F0, 2'd2}) begin
         n_fail++; $display("FAIL rd_done_ignored: got %h expected %h", obs(), {4'b1000, 4'b0100, 12'h0F0, 2'd2});
      end
      bus.Wr_done = 1'b1; bus.Wr_req = 1'b0;
      #1;
      n_checks++;
      if (bus.Wr_en !== 1'b1) begin
         n_fail++; $display("FAIL wr_en_on_done: got %b expected 1", bus.Wr_en);
      end
      step();
      bus.Wr_done = 1'b0;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fail++; $display("FAIL idle_between: got %h expected %h", obs(), V_IDLE);
      end
      step();
      n_checks++;
      if (obs() !== {4'b0100, 4'b0101, 12'h155, 2'd1}) begin
         n_fail++; $display("FAIL read_after: got %h expected %h", obs(), {4'b0100, 4'b0101, 12'h155, 2'd1});
      end
      bus.Rd_done = 1'b1; bus.Rd_req = 1'b0;
      step();
      bus.Rd_done = 1'b0;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fail++; $display("FAIL read_release: got %h expected %h", obs(), V_IDLE);
      end
   endtask

   task automatic test_refresh_during_write();
      bus.Wr_req = 1'b1; bus.Wr_cmd = 4'b0100; bus.Wr_addr = 12'h3C3; bus.Wr_ba = 2'd3;
      step();
      run_to(RP - 2);
      n_checks++;
      if (obs() !== {4'b1000, 4'b0100, 12'h3C3, 2'd3}) begin
         n_fail++; $display("FAIL wr_before_tc: got %h expected %h", obs(), {4'b1000, 4'b0100, 12'h3C3, 2'd3});
      end
      bus.Rd_req = 1'b1; bus.Rd_cmd = 4'b0101; bus.Rd_addr = 12'h011; bus.Rd_ba = 2'd0;
      step();
      n_checks++;
      if (obs() !== {4'b1010, 4'b0100, 12'h3C3, 2'd3}) begin
         n_fail++; $display("FAIL wr_no_preempt: got %h expected %h", obs(), {4'b1010, 4'b0100, 12'h3C3, 2'd3});
      end
      step();
      n_checks++;
      if (obs() !== {4'b1010, 4'b0100, 12'h3C3, 2'd3}) begin
         n_fail++; $display("FAIL pend_sticky: got %h expected %h", obs(), {4'b1010, 4'b0100, 12'h3C3, 2'd3});
      end
      bus.Wr_done = 1'b1; bus.Wr_req = 1'b0;
      step();
      bus.Wr_done = 1'b0;
      n_checks++;
      if (obs() !== V_PEND) begin
         n_fail++; $display("FAIL idle_pend_over_rd: got %h expected %h", obs(), V_PEND);
      end
      step();
      n_checks++;
      if (obs() !== V_PRE) begin
         n_fail++; $display("FAIL aref_before_rd: got %h expected %h", obs(), V_PRE);
      end
      repeat (19) step();
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fail++; $display("FAIL idle_after_aref: got %h expected %h", obs(), V_IDLE);
      end
      step();
      n_checks++;
      if (obs() !== {4'b0100, 4'b0101, 12'h011, 2'd0}) begin
         n_fail++; $display("FAIL rd_after_aref: got %h expected %h", obs(), {4'b0100, 4'b0101, 12'h011, 2'd0});
      end
      bus.Rd_done = 1'b1; bus.Rd_req = 1'b0;
      step();
      bus.Rd_done = 1'b0;
   endtask

   task automatic test_reset_mid_aref();
      run_to(RP - 1);
      step();
      repeat (5) step();
      n_checks++;
      if (obs() !== {4'b0001, 4'b0111, 12'h000, 2'b00}) begin
         n_fail++; $display("FAIL aref_k5: got %h expected %h", obs(), {4'b0001, 4'b0111, 12'h000, 2'b00});
      end
      bus.Init_cmd = 4'b1010; bus.Init_addr = 12'h2AA;
      rst_n = 1'b0; running = 1'b0;
      step();
      n_checks++;
      if (obs() !== {4'b0000, 4'b1010, 12'h2AA, 2'b00}) begin
         n_fail++; $display("FAIL reset_mid_aref: got %h expected %h", obs(), {4'b0000, 4'b1010, 12'h2AA, 2'b00});
      end
      step();
      rst_n = 1'b1;
      step();
      bus.Init_done = 1'b1;
      step();
      running = 1'b1; tcount = 0;
      bus.Init_done = 1'b0;
      run_to(RP - 2);
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fail++; $display("FAIL restart_before_tc: got %h expected %h", obs(), V_IDLE);
      end
      step();
      n_checks++;
      if (obs() !== V_PEND) begin
         n_fail++; $display("FAIL restart_tc: got %h expected %h", obs(), V_PEND);
      end
      step();
      n_checks++;
      if (obs() !== V_PRE) begin
         n_fail++; $display("FAIL restart_aref: got %h expected %h", obs(), V_PRE);
      end
   endtask

   initial begin
      test_reset();
      test_refresh();
      test_priority();
      test_refresh_during_write();
      test_reset_mid_aref();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
